mu0_memory_delay1: RTL and testbench



---
 rtl/mu0_memory_delay1.sv | 39 +++
 tb/tb_mu0_memory_delay1.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mu0_memory_delay1.sv
// mu0_memory_delay1: 4096x16 MU0 bus memory with 1-cycle read latency, OUT port and tick counter
module mu0_memory_delay1 #(
  parameter string       INIT_FILE = "",
  parameter logic [11:0] OUT_ADDR  = 12'hFFF,
  parameter logic [11:0] TICK_ADDR = 12'hFFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        protocol_error
);
  logic [15:0] mem [4096];
  logic [15:0] tick;
  logic        is_out, is_tick;
  assign is_out  = address == OUT_ADDR;
  assign is_tick = address == TICK_ADDR;
  always_ff @(posedge clk)
    if (!rst && write && !is_out && !is_tick) mem[address] <= writedata;
  always_ff @(posedge clk)
    if (rst) begin
      readdata       <= '0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      tick           <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (read && !write) readdata <= is_tick ? tick : is_out ? out_data : mem[address];
      out_valid      <= write && is_out;
      if (write && is_out) out_data <= writedata;
      tick           <= tick + 16'd1;
      protocol_error <= protocol_error | (read & write);
    end
endmodule

// File: tb/tb_mu0_memory_delay1.sv
// tb_mu0_memory_delay1: randomized and directed checks of mu0_memory_delay1 against a behavioural model.
module tb_mu0_memory_delay1;
    localparam logic [11:0] OUT_A  = 12'hFFF;
    localparam logic [11:0] TICK_A = 12'hFFE;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] address = '0;
    logic        read = 1'b0, write = 1'b0;
    logic [15:0] writedata = '0;
    logic [15:0] readdata, out_data;
    logic        out_valid, protocol_error;

    int pass_cnt = 0, total_cnt = 0;

    logic [15:0] m_mem [4096];
    logic [15:0] m_rd = '0, m_od = '0, m_tick = '0;
    logic        m_ov = 1'b0, m_pe = 1'b0, live = 1'b0;

    mu0_memory_delay1 dut (
        .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(readdata), .out_valid(out_valid),
        .out_data(out_data), .protocol_error(protocol_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: outputs after each edge, derived from the bus rules
    always @(posedge clk) begin
        if (rst) begin
            live = 1'b1;
            {m_rd, m_od, m_tick} = '0;
            m_ov = 1'b0;
            m_pe = 1'b0;
        end else begin
            if (read && !write)
                m_rd = (address == TICK_A) ? m_tick : (address == OUT_A) ? m_od : m_mem[address];
            m_ov = write && address == OUT_A;
            if (m_ov) m_od = writedata;
            else if (write && address != TICK_A) m_mem[address] = writedata;
            if (read && write) m_pe = 1'b1;
            m_tick = m_tick + 16'd1;
        end
        #1;
        if (live) begin
            chk("cmp_readdata", readdata, m_rd);
            chk("cmp_out_valid", {15'd0, out_valid}, {15'd0, m_ov});
            chk("cmp_out_data", out_data, m_od);
            chk("cmp_protocol_error", {15'd0, protocol_error}, {15'd0, m_pe});
        end
    end

    task automatic step(input logic r, input logic w, input logic [11:0] a, input logic [15:0] d);
        read = r;
        write = w;
        address = a;
        writedata = d;
        @(negedge clk);
    endtask

    initial begin
        int n;
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_readdata", readdata, 16'h0000);
        chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_protocol_error", {15'd0, protocol_error}, 16'h0000);
        rst = 1'b0;
        repeat (9) step(0, 0, 0, 0);
        step(1, 0, TICK_A, 0);
        chk("tick_after_9_idle", readdata, 16'd9);

        for (int i = 0; i < 4094; i++) step(0, 1, 12'(i), 16'($urandom));

        step(0, 1, 12'h010, 16'h1234);
        step(1, 0, 12'h010, 0);
        chk("raw_0x010", readdata, 16'h1234);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("hold_0x010", readdata, 16'h1234);

        step(0, 1, 12'h000, 16'hAAAA);
        step(0, 1, 12'h001, 16'h5555);
        step(1, 0, 12'h000, 0);
        chk("b2b_read0", readdata, 16'hAAAA);
        step(1, 0, 12'h001, 0);
        chk("b2b_read1", readdata, 16'h5555);

        step(0, 1, OUT_A, 16'hFFFB);
        chk("out_valid_pulse", {15'd0, out_valid}, 16'h0001);
        chk("out_data_fffb", out_data, 16'hFFFB);
        step(1, 0, OUT_A, 0);
        chk("out_valid_drop", {15'd0, out_valid}, 16'h0000);
        chk("read_out_addr", readdata, 16'hFFFB);

        step(1, 1, 12'h020, 16'h0F0F);
        chk("rw_readdata_kept", readdata, 16'hFFFB);
        chk("rw_protocol_error", {15'd0, protocol_error}, 16'h0001);
        step(1, 0, 12'h020, 0);
        chk("rw_write_done", readdata, 16'h0F0F);

        step(0, 1, OUT_A, 16'h0001);
        step(0, 1, OUT_A, 16'h0002);
        chk("out_b2b_valid", {15'd0, out_valid}, 16'h0001);
        chk("out_b2b_data", out_data, 16'h0002);
        step(0, 1, TICK_A, 16'hDEAD);

        for (int i = 0; i < 3000; i++) begin
            int sel = $urandom_range(0, 7);
            int op = $urandom_range(0, 9);
            logic [11:0] a = sel == 0 ? OUT_A : sel == 1 ? TICK_A : 12'($urandom);
            step(op < 4 || op == 7, op >= 4 && op <= 7, a, 16'($urandom));
        end
        chk("pe_sticky", {15'd0, protocol_error}, 16'h0001);

        n = 0;
        while (m_tick != 16'hFFFF && n < 70000) begin
            step(0, 0, 0, 0);
            n++;
        end
        chk("wrap_wait_bound", {15'd0, m_tick == 16'hFFFF}, 16'h0001);
        step(1, 0, TICK_A, 0);
        chk("tick_ffff", readdata, 16'hFFFF);
        step(1, 0, TICK_A, 0);
        chk("tick_wrap_0", readdata, 16'h0000);

        step(0, 1, 12'h030, 16'h4321);
        step(0, 1, OUT_A, 16'h9999);
        rst = 1'b1;
        step(0, 1, 12'h030, 16'h7777);
        rst = 1'b0;
        chk("rstw_readdata", readdata, 16'h0000);
        chk("rstw_out_data", out_data, 16'h0000);
        chk("rstw_out_valid", {15'd0, out_valid}, 16'h0000);
        chk("rstw_pe", {15'd0, protocol_error}, 16'h0000);
        step(1, 0, 12'h030, 0);
        chk("rstw_mem_kept", readdata, 16'h4321);
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
